// File: rtl/learn_note_feeder.sv
// learn_note_feeder: walks the song ROM one entry at a time and feeds note/shift/output_ready
// to the scrolling renderer, paced by the shared scroll step and stalled with the renderer.
module learn_note_feeder #(
    parameter int PERIOD    = 100000,
    parameter int ADDR_W    = 8,
    parameter int SONG_LEN  = 256,
    parameter int GAP_STEPS = 1
) (
    input  logic              vga_clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              pause_i,
    input  logic              advance_en_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic [7:0]        note_o,
    output logic [1:0]        shift_o,
    output logic              output_ready_o,
    output logic              step_tick_o,
    output logic              busy_o,
    output logic              done_o
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, GAP, NEXT, DONE} state_t;

    localparam logic [19:0]       CNT_LAST  = 20'(PERIOD - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
    localparam logic [3:0]        GAP_INIT  = 4'(GAP_STEPS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        note_q, note_d;
    logic [1:0]        shift_q, shift_d;
    logic              ready_q, ready_d;
    logic [5:0]        dur_q, dur_d;
    logic [3:0]        gap_q, gap_d;
    logic [19:0]       cnt_q, cnt_d;
    logic              idle, tick;

    assign idle           = state_q == IDLE || state_q == DONE;
    // A wrap with advance_en low is a lost step, exactly as the renderer skips its shift.
    assign tick           = !idle && !pause_i && advance_en_i && cnt_q == CNT_LAST;
    assign rom_addr_o     = addr_q;
    assign note_o         = note_q;
    assign shift_o        = shift_q;
    assign output_ready_o = ready_q;
    assign step_tick_o    = tick;
    assign busy_o         = !idle;
    assign done_o         = state_q == DONE;

    always_ff @(posedge vga_clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            note_q  <= '0;
            shift_q <= '0;
            ready_q <= 1'b0;
            dur_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d   = idle ? '0 : pause_i ? cnt_q : cnt_q == CNT_LAST ? '0 : cnt_q + 20'd1;
        state_d = state_q;
        addr_d  = addr_q;
        note_d  = note_q;
        shift_d = shift_q;
        ready_d = ready_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        if (idle) begin
            if (start_i) begin
                state_d = FETCH;
                addr_d  = '0;
            end
        end else if (!pause_i) begin
            case (state_q)
                FETCH: state_d = WAIT;
                WAIT: begin
                    if (rom_data_i[15:10] == 6'd0) begin
                        state_d = DONE;
                        note_d  = '0;
                        shift_d = '0;
                    end else begin
                        state_d = PLAY;
                        note_d  = rom_data_i[7:0];
                        shift_d = rom_data_i[9:8];
                        dur_d   = rom_data_i[15:10];
                        ready_d = 1'b1;
                    end
                end
                PLAY: begin
                    if (tick && dur_q == 6'd1) begin
                        ready_d = 1'b0;
                        note_d  = '0;
                        gap_d   = GAP_INIT;
                        state_d = GAP_INIT == 4'd0 ? NEXT : GAP;
                    end else if (tick) begin
                        dur_d = dur_q - 6'd1;
                    end
                end
                GAP: begin
                    if (tick) begin
                        gap_d   = gap_q - 4'd1;
                        state_d = gap_q == 4'd1 ? NEXT : GAP;
                    end
                end
                NEXT: begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = DONE;
                        shift_d = '0;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = FETCH;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end
endmodule

// File: tb/tb_learn_note_feeder.sv
// tb_learn_note_feeder: directed scenarios plus randomized traffic, checked every cycle
// against a step-level song model and a few hand-computed timing literals.
module tb_learn_note_feeder;
    localparam int P    = 4;
    localparam int LEN  = 6;
    localparam int GAPN = 1;

    logic        vga_clk = 0, rst_n = 0, start = 0, pause = 0, adv = 1;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [7:0]  note;
    logic [1:0]  shift;
    logic        ready, tick, busy, done;
    logic [15:0] rom [256];
    int          n_tests = 0, n_fail = 0, rdy_cycles = 0;
    bit          chk_en = 0;

    // Model: song position, remaining fetch latency, steps left in note and in gap.
    bit          m_active = 0, m_done = 0, m_ready = 0;
    int          m_addr = 0, m_cnt = 0, m_lat = 0, m_play = 0, m_gap = 0;
    logic [7:0]  m_note = '0;
    logic [1:0]  m_shift = '0;

    learn_note_feeder #(.PERIOD(P), .ADDR_W(8), .SONG_LEN(LEN), .GAP_STEPS(GAPN)) dut (
        .vga_clk_i(vga_clk), .rst_n_i(rst_n), .start_i(start), .pause_i(pause),
        .advance_en_i(adv), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .note_o(note), .shift_o(shift), .output_ready_o(ready), .step_tick_o(tick),
        .busy_o(busy), .done_o(done)
    );

    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) rom_data <= rom[rom_addr];

    function automatic bit m_tick();
        return m_active && !pause && adv && m_cnt == P - 1;
    endfunction

    task automatic m_finish();
        m_active = 0; m_done = 1; m_note = '0; m_shift = '0; m_ready = 0;
    endtask

    always @(posedge vga_clk) begin
        bit tk;
        tk = m_tick();
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_addr = 0; m_cnt = 0; m_lat = 0;
            m_play = 0; m_gap = 0; m_note = '0; m_shift = '0; m_ready = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_done = 0; m_addr = 0; m_cnt = 0; m_lat = 2;
            end
        end else if (!pause) begin
            m_cnt = (m_cnt + 1) % P;
            if (m_lat == 2) m_lat = 1;
            else if (m_lat == 1) begin
                m_lat = 0;
                if (rom[m_addr][15:10] == 6'd0) m_finish();
                else begin
                    m_note = rom[m_addr][7:0]; m_shift = rom[m_addr][9:8];
                    m_play = int'(rom[m_addr][15:10]); m_ready = 1;
                end
            end else if (m_play > 0) begin
                if (tk) begin
                    m_play--;
                    if (m_play == 0) begin m_ready = 0; m_note = '0; m_gap = GAPN; end
                end
            end else if (m_gap > 0) begin
                if (tk) m_gap--;
            end else if (m_addr == LEN - 1) m_finish();
            else begin m_addr++; m_lat = 2; end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge vga_clk) if (chk_en) begin
        check("note", note, m_note);
        check("shift", shift, m_shift);
        check("output_ready", ready, m_ready);
        check("step_tick", tick, m_tick());
        check("busy", busy, m_active);
        check("done", done, m_done);
        check("rom_addr", rom_addr, m_addr);
        if (ready) rdy_cycles++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1; cyc(1); start = 0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 500) begin cyc(1); k++; end
        check(name, done, 1);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    initial begin
        clear_rom();
        cyc(2);
        chk_en = 1;
        check("reset_busy", busy, 0);
        check("reset_addr", rom_addr, 0);
        rst_n = 1;
        cyc(1);

        rom[0] = 16'h0801;
        rdy_cycles = 0;
        pulse_start();
        check("t1_lat1", ready, 0);
        cyc(1);
        check("t1_lat2", ready, 0);
        cyc(1);
        check("t1_lat3", ready, 1);
        check("t1_note", note, 8'h01);
        wait_done("t1_done");
        check("t1_ready_cycles", rdy_cycles, 6);
        check("t1_addr", rom_addr, 1);
        check("t1_busy", busy, 0);
        check("t1_model_addr", m_addr, 1);

        rdy_cycles = 0;
        pulse_start();
        cyc(3);
        adv = 0;
        cyc(12);
        adv = 1;
        wait_done("t2_done");
        check("t2_ready_cycles", rdy_cycles, 18);

        rdy_cycles = 0;
        pulse_start();
        cyc(2);
        pause = 1;
        cyc(5);
        check("t3_cnt_held", dut.cnt_q, 2);
        cyc(5);
        pause = 0;
        cyc(1);
        check("t3_cnt_resume", dut.cnt_q, 3);
        wait_done("t3_done");
        check("t3_ready_cycles", rdy_cycles, 16);

        pulse_start();
        cyc(4);
        check("t4_ready_before", ready, 1);
        rst_n = 0;
        cyc(1);
        check("t4_note", note, 0);
        check("t4_ready", ready, 0);
        check("t4_busy", busy, 0);
        rst_n = 1;
        cyc(1);
        pulse_start();
        check("t4_restart_addr", rom_addr, 0);
        check("t4_restart_busy", busy, 1);
        wait_done("t4_done");

        for (int i = 0; i < LEN; i++) rom[i] = {6'd1, 2'b01, 8'h01 << i};
        pulse_start();
        cyc(20);
        pulse_start();
        wait_done("t5_done");
        check("t5_last_addr", rom_addr, LEN - 1);
        pulse_start();
        check("t5_restart_addr", rom_addr, 0);
        check("t5_restart_done", done, 0);
        wait_done("t5_done2");

        clear_rom();
        rom[0] = 16'h0604;
        rom[1] = 16'h0604;
        pulse_start();
        begin
            int k = 0;
            while (!ready && k < 50) begin cyc(1); k++; end
            check("t6_first_shift", shift, 2'b10);
            k = 0;
            while (ready && k < 50) begin cyc(1); k++; end
            k = 0;
            while (!ready && k < 50) begin check("t6_gap_shift", shift, 2'b10); cyc(1); k++; end
            check("t6_gap_cycles", k, 7);
            check("t6_second_note", note, 8'h04);
        end
        wait_done("t6_done");

        for (int i = 0; i < LEN; i++) begin
            logic [1:0] s;
            s = ($urandom % 3 == 0) ? 2'b01 : ($urandom % 2 == 0) ? 2'b00 : 2'b10;
            rom[i] = {6'($urandom % 4), s, ($urandom % 3 == 0) ? 8'h00 : 8'h01 << ($urandom % 8)};
        end
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom % 16 == 0);
            pause = ($urandom % 8 == 0);
            adv   = ($urandom % 4 != 0);
            rst_n = ($urandom % 300 != 0);
            cyc(1);
        end
        start = 0; pause = 0; adv = 1; rst_n = 1;
        cyc(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
